// File: rtl/d5m_pattern_source.sv
`default_nettype none
// ============================================================================
//  Module   : d5m_pattern_source
//  Purpose  : Synthetic TRDB-D5M pixel-bus transmitter. Emits FVAL/LVAL
//             framed 12-bit pixel data with a per-tick strobe. It replaces
//             the camera so the capture path can be driven with known
//             frames. The test pattern is selectable; active area and
//             blanking are set by parameters.
//  Ports    : piul1Clock        system clock
//             piul1Reset_n      asynchronous active-low reset
//             piul1Enable       run frames while high (level)
//             piulPattern       0 bars, 1 diagonal ramp, 2 checker, 3 flat
//             poul1PixelStrobe  one-cycle pulse after every pixel tick
//             poul1FrameValid   FVAL
//             poul1LineValid    LVAL
//             poulPixelData     pixel value, 0 while LVAL is low
//             poul1FrameDone    one-cycle pulse when FVAL falls
//             poulFrameCount    completed frames (wraps)
//             poul1Busy         high whenever the FSM is not IDLE
//  Options  : D5M_PATTERN_BAYER_EN - pattern 0 becomes an 8-bar RGB colour
//             bar set laid out as a Bayer mosaic instead of grey bars.
//  Revision : 1.0 - initial release
// ============================================================================
module d5m_pattern_source #(
    parameter int ACTIVE_COLS   = 640,
    parameter int ACTIVE_ROWS   = 480,
    parameter int H_BLANK       = 16,
    parameter int V_BLANK_LINES = 4,
    parameter int DATA_WIDTH    = 12,
    parameter int CLK_DIV       = 2
) (
    input  logic                  piul1Clock,
    input  logic                  piul1Reset_n,
    input  logic                  piul1Enable,
    input  logic [1:0]            piulPattern,
    output logic                  poul1PixelStrobe,
    output logic                  poul1FrameValid,
    output logic                  poul1LineValid,
    output logic [DATA_WIDTH-1:0] poulPixelData,
    output logic                  poul1FrameDone,
    output logic [15:0]           poulFrameCount,
    output logic                  poul1Busy
);

    localparam int MAXV     = (1 << DATA_WIDTH) - 1;
    localparam int BAR_W    = ACTIVE_COLS / 8;
    localparam int VB_TICKS = V_BLANK_LINES * (ACTIVE_COLS + H_BLANK);
    // Counters are at least 4 bits so bit 3 exists for the checkerboard.
    localparam int CNT_W    = ($clog2(VB_TICKS + 1) > 4) ? $clog2(VB_TICKS + 1) : 4;
    localparam int ROW_W    = ($clog2(ACTIVE_ROWS) > 4) ? $clog2(ACTIVE_ROWS) : 4;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]      C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]      C_HB_LAST  = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0]      C_COL_LAST = CNT_W'(ACTIVE_COLS - 1);
    localparam logic [CNT_W-1:0]      C_VB_LAST  = CNT_W'(VB_TICKS - 1);
    localparam logic [ROW_W-1:0]      C_ROW_LAST = ROW_W'(ACTIVE_ROWS - 1);
    localparam logic [DATA_WIDTH-1:0] C_MAXV     = '1;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_FRAME_START = 3'd1,
        S_LINE_ACTIVE = 3'd2,
        S_LINE_BLANK  = 3'd3,
        S_FRAME_BLANK = 3'd4
    } state_t;

    state_t                  state_q;
    logic [DIV_W-1:0]        div_q;
    logic [CNT_W-1:0]        cnt_q;     // column in LINE_ACTIVE, tick count in blanking
    logic [ROW_W-1:0]        row_q;
    logic [1:0]              pat_q;     // pattern held for the whole frame
    logic [DATA_WIDTH-1:0]   flat_q;    // frame count captured at frame start
    logic                    strobe_q;
    logic                    fval_q;
    logic                    lval_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    done_q;
    logic [15:0]             count_q;
    logic                    busy_q;

    logic                    tick;
    logic [CNT_W-1:0]        pix_col_d;
    logic [ROW_W-1:0]        pix_row_d;
    logic [2:0]              bar_d;
    logic [DATA_WIDTH-1:0]   bar_val_d;
    logic [DATA_WIDTH-1:0]   pix_d;

    assign tick = (div_q == C_DIV_LAST);

    // Coordinates of the pixel that goes on the bus at the next tick, should
    // the FSM enter or stay in LINE_ACTIVE.
    always_comb begin
        pix_col_d = '0;
        pix_row_d = '0;
        case (state_q)
            S_LINE_ACTIVE: begin
                pix_col_d = cnt_q + CNT_W'(1);
                pix_row_d = row_q;
            end
            S_LINE_BLANK:  pix_row_d = row_q + ROW_W'(1);
            default:       ;
        endcase
    end

    // Bar index by comparison against constant bar boundaries, no divider.
    always_comb begin
        bar_d = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(pix_col_d) >= k * BAR_W) begin
                bar_d = 3'(k);
            end
        end
    end

`ifdef D5M_PATTERN_BAYER_EN
    logic [2:0] rgb_d;
    logic       chan_on_d;

    // Bar colours as {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        case (bar_d)
            3'd0:    rgb_d = 3'b111;
            3'd1:    rgb_d = 3'b110;
            3'd2:    rgb_d = 3'b011;
            3'd3:    rgb_d = 3'b010;
            3'd4:    rgb_d = 3'b101;
            3'd5:    rgb_d = 3'b100;
            3'd6:    rgb_d = 3'b001;
            default: rgb_d = 3'b000;
        endcase
        // Mosaic: even/even G, even/odd R, odd/even B, odd/odd G.
        case ({pix_row_d[0], pix_col_d[0]})
            2'b01:   chan_on_d = rgb_d[2];
            2'b10:   chan_on_d = rgb_d[0];
            default: chan_on_d = rgb_d[1];
        endcase
        bar_val_d = chan_on_d ? C_MAXV : '0;
    end
`else
    always_comb begin
        case (bar_d)
            3'd0:    bar_val_d = DATA_WIDTH'((0 * MAXV) / 7);
            3'd1:    bar_val_d = DATA_WIDTH'((1 * MAXV) / 7);
            3'd2:    bar_val_d = DATA_WIDTH'((2 * MAXV) / 7);
            3'd3:    bar_val_d = DATA_WIDTH'((3 * MAXV) / 7);
            3'd4:    bar_val_d = DATA_WIDTH'((4 * MAXV) / 7);
            3'd5:    bar_val_d = DATA_WIDTH'((5 * MAXV) / 7);
            3'd6:    bar_val_d = DATA_WIDTH'((6 * MAXV) / 7);
            default: bar_val_d = DATA_WIDTH'(MAXV);
        endcase
    end
`endif

    always_comb begin
        case (pat_q)
            2'd0:    pix_d = bar_val_d;
            2'd1:    pix_d = DATA_WIDTH'(int'(pix_col_d) + int'(pix_row_d));
            2'd2:    pix_d = (pix_col_d[3] ^ pix_row_d[3]) ? C_MAXV : '0;
            default: pix_d = flat_q;
        endcase
    end

    // Bus outputs change only on tick edges; the strobe and FrameDone are
    // single-cycle pulses in the cycle that follows the tick edge.
    always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
        if (!piul1Reset_n) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            cnt_q    <= '0;
            row_q    <= '0;
            pat_q    <= '0;
            flat_q   <= '0;
            strobe_q <= 1'b0;
            fval_q   <= 1'b0;
            lval_q   <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            strobe_q <= tick;
            done_q   <= 1'b0;
            div_q    <= tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                case (state_q)
                    S_IDLE: begin
                        if (piul1Enable) begin
                            state_q <= S_FRAME_START;
                            cnt_q   <= '0;
                            pat_q   <= piulPattern;
                            flat_q  <= DATA_WIDTH'(count_q);
                            fval_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_FRAME_START: begin
                        if (cnt_q == C_HB_LAST) begin
                            state_q <= S_LINE_ACTIVE;
                            cnt_q   <= '0;
                            row_q   <= '0;
                            lval_q  <= 1'b1;
                            data_q  <= pix_d;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_LINE_ACTIVE: begin
                        if (cnt_q == C_COL_LAST) begin
                            cnt_q  <= '0;
                            lval_q <= 1'b0;
                            data_q <= '0;
                            if (row_q == C_ROW_LAST) begin
                                state_q <= S_FRAME_BLANK;
                                fval_q  <= 1'b0;
                                done_q  <= 1'b1;
                                count_q <= count_q + 16'd1;
                            end else begin
                                state_q <= S_LINE_BLANK;
                            end
                        end else begin
                            cnt_q  <= cnt_q + CNT_W'(1);
                            data_q <= pix_d;
                        end
                    end
                    S_LINE_BLANK: begin
                        if (cnt_q == C_HB_LAST) begin
                            state_q <= S_LINE_ACTIVE;
                            cnt_q   <= '0;
                            row_q   <= row_q + ROW_W'(1);
                            lval_q  <= 1'b1;
                            data_q  <= pix_d;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_FRAME_BLANK: begin
                        if (cnt_q == C_VB_LAST) begin
                            cnt_q <= '0;
                            row_q <= '0;
                            if (piul1Enable) begin
                                state_q <= S_FRAME_START;
                                pat_q   <= piulPattern;
                                flat_q  <= DATA_WIDTH'(count_q);
                                fval_q  <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        fval_q  <= 1'b0;
                        lval_q  <= 1'b0;
                        data_q  <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign poul1PixelStrobe = strobe_q;
    assign poul1FrameValid  = fval_q;
    assign poul1LineValid   = lval_q;
    assign poulPixelData    = data_q;
    assign poul1FrameDone   = done_q;
    assign poulFrameCount   = count_q;
    assign poul1Busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_d5m_pattern_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_d5m_pattern_source
//  Purpose  : Directed self-checking bench for d5m_pattern_source. Three
//             instances: a small 8x4 frame at CLK_DIV=1 (dut_a), the same
//             frame at CLK_DIV=3 (dut_b) and the default 640x480 build
//             (dut_c) for the colour-bar values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_d5m_pattern_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic [1:0] pat_a = 2'd0, pat_b = 2'd0, pat_c = 2'd0;

    logic stb_a, fv_a, lv_a, dn_a, bz_a;
    logic stb_b, fv_b, lv_b, dn_b, bz_b;
    logic stb_c, fv_c, lv_c, dn_c, bz_c;
    logic [11:0] px_a, px_b, px_c;
    logic [15:0] fc_a, fc_b, fc_c;

    int n_cmp = 0;
    int n_bad = 0;

    d5m_pattern_source #(.ACTIVE_COLS(8), .ACTIVE_ROWS(4), .H_BLANK(2),
                         .V_BLANK_LINES(1), .DATA_WIDTH(12), .CLK_DIV(1)) dut_a (
        .piul1Clock(clk), .piul1Reset_n(rst_n), .piul1Enable(en_a), .piulPattern(pat_a),
        .poul1PixelStrobe(stb_a), .poul1FrameValid(fv_a), .poul1LineValid(lv_a),
        .poulPixelData(px_a), .poul1FrameDone(dn_a), .poulFrameCount(fc_a), .poul1Busy(bz_a));

    d5m_pattern_source #(.ACTIVE_COLS(8), .ACTIVE_ROWS(4), .H_BLANK(2),
                         .V_BLANK_LINES(1), .DATA_WIDTH(12), .CLK_DIV(3)) dut_b (
        .piul1Clock(clk), .piul1Reset_n(rst_n), .piul1Enable(en_b), .piulPattern(pat_b),
        .poul1PixelStrobe(stb_b), .poul1FrameValid(fv_b), .poul1LineValid(lv_b),
        .poulPixelData(px_b), .poul1FrameDone(dn_b), .poulFrameCount(fc_b), .poul1Busy(bz_b));

    d5m_pattern_source dut_c (
        .piul1Clock(clk), .piul1Reset_n(rst_n), .piul1Enable(en_c), .piulPattern(pat_c),
        .poul1PixelStrobe(stb_c), .poul1FrameValid(fv_c), .poul1LineValid(lv_c),
        .poulPixelData(px_c), .poul1FrameDone(dn_c), .poulFrameCount(fc_c), .poul1Busy(bz_c));

    // Expected {FVAL, LVAL, data} of the 8x4 frame at tick t (50-tick frame:
    // 2 start-blank ticks, 4 lines of 8 active + 2 blank, 10 frame-blank).
    function automatic logic [13:0] model_a(input int t, input bit ramp, input int flatv);
        int p, q, r, c;
        p = t % 50;
        if (p >= 40) return 14'd0;
        if (p < 2)   return {2'b10, 12'd0};
        q = p - 2;
        r = q / 10;
        c = q % 10;
        if (c >= 8)  return {2'b10, 12'd0};
        return {2'b11, (ramp ? 12'(c + r) : 12'(flatv))};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({stb_a, fv_a, lv_a, px_a, dn_a, fc_a, bz_a} !== 33'd0) begin
            n_bad++;
            $display("FAIL reset_a got %h want 0", {stb_a, fv_a, lv_a, px_a, dn_a, fc_a, bz_a});
        end
        n_cmp++;
        if ({stb_c, fv_c, lv_c, px_c, dn_c, fc_c, bz_c} !== 33'd0) begin
            n_bad++;
            $display("FAIL reset_c got %h want 0", {stb_c, fv_c, lv_c, px_c, dn_c, fc_c, bz_c});
        end
    endtask

    // Ramp frame, pattern switched to flat mid-frame: frame 0 keeps the
    // ramp, frame 1 shows the flat value 1 (count at its start).
    task automatic test_frame();
        logic [13:0] exp_bus;
        en_a  = 1'b1;
        pat_a = 2'd1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            @(negedge clk);
            exp_bus = model_a(t, (t < 50), t / 50);
            n_cmp++;
            if ({fv_a, lv_a, px_a} !== exp_bus) begin
                n_bad++;
                $display("FAIL frame_bus t=%0d got %h want %h", t, {fv_a, lv_a, px_a}, exp_bus);
            end
            n_cmp++;
            if (dn_a !== ((t % 50) == 40)) begin
                n_bad++;
                $display("FAIL frame_done t=%0d got %b want %b", t, dn_a, ((t % 50) == 40));
            end
            n_cmp++;
            if (fc_a !== 16'((t < 40) ? 0 : (t - 40) / 50 + 1)) begin
                n_bad++;
                $display("FAIL frame_count t=%0d got %0d want %0d", t, fc_a, (t < 40) ? 0 : (t - 40) / 50 + 1);
            end
            n_cmp++;
            if ({stb_a, bz_a} !== 2'b11) begin
                n_bad++;
                $display("FAIL frame_strobe_busy t=%0d got %b want 11", t, {stb_a, bz_a});
            end
            if (t == 20) pat_a = 2'd3;
        end
        en_a = 1'b0;
    endtask

    task automatic test_enable_drop();
        en_a  = 1'b1;
        pat_a = 2'd1;
        do_reset();
        for (int t = 0; t < 80; t++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({fv_a, lv_a, px_a} !== ((t < 50) ? model_a(t, 1'b1, 0) : 14'd0)) begin
                n_bad++;
                $display("FAIL drop_bus t=%0d got %h want %h", t, {fv_a, lv_a, px_a},
                         ((t < 50) ? model_a(t, 1'b1, 0) : 14'd0));
            end
            n_cmp++;
            if ({bz_a, dn_a} !== {(t < 50), (t == 40)}) begin
                n_bad++;
                $display("FAIL drop_busy_done t=%0d got %b want %b", t, {bz_a, dn_a}, {(t < 50), (t == 40)});
            end
            n_cmp++;
            if (fc_a !== 16'((t >= 40) ? 1 : 0)) begin
                n_bad++;
                $display("FAIL drop_count t=%0d got %0d want %0d", t, fc_a, (t >= 40) ? 1 : 0);
            end
            if (t == 15) en_a = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        en_a  = 1'b1;
        pat_a = 2'd1;
        do_reset();
        repeat (56) begin
            @(posedge clk);
            @(negedge clk);
        end
        // Tick 55: frame 1, row 0 col 3, one frame already completed.
        n_cmp++;
        if ({lv_a, px_a, fc_a} !== {1'b1, 12'd3, 16'd1}) begin
            n_bad++;
            $display("FAIL midreset_pre got %h want %h", {lv_a, px_a, fc_a}, {1'b1, 12'd3, 16'd1});
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({stb_a, fv_a, lv_a, px_a, dn_a, fc_a, bz_a} !== 33'd0) begin
            n_bad++;
            $display("FAIL midreset_clear got %h want 0", {stb_a, fv_a, lv_a, px_a, dn_a, fc_a, bz_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({fv_a, lv_a, px_a, dn_a, fc_a} !== {model_a(t, 1'b1, 0), (t == 40), 16'((t >= 40) ? 1 : 0)}) begin
                n_bad++;
                $display("FAIL midreset_frame t=%0d got %h want %h", t, {fv_a, lv_a, px_a, dn_a, fc_a},
                         {model_a(t, 1'b1, 0), (t == 40), 16'((t >= 40) ? 1 : 0)});
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_clkdiv();
        logic [13:0] prev_bus;
        logic        prev_fv;
        int last_stb, last_rise, last_done, n_rise, n_done;
        last_stb = -1; last_rise = -1; last_done = -1; n_rise = 0; n_done = 0;
        en_b  = 1'b1;
        pat_b = 2'd1;
        do_reset();
        prev_bus = {fv_b, lv_b, px_b};
        prev_fv  = fv_b;
        for (int cyc = 0; cyc < 480; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (({fv_b, lv_b, px_b} !== prev_bus) && !stb_b) begin
                n_bad++;
                $display("FAIL div_change_off_strobe cyc=%0d got %h want %h", cyc, {fv_b, lv_b, px_b}, prev_bus);
            end
            if (stb_b) begin
                if (last_stb >= 0) begin
                    n_cmp++;
                    if (cyc - last_stb != 3) begin
                        n_bad++;
                        $display("FAIL div_strobe_gap cyc=%0d got %0d want 3", cyc, cyc - last_stb);
                    end
                end
                last_stb = cyc;
            end
            if (fv_b && !prev_fv) begin
                if (last_rise >= 0) begin
                    n_cmp++;
                    if (cyc - last_rise != 150) begin
                        n_bad++;
                        $display("FAIL div_frame_len cyc=%0d got %0d want 150", cyc, cyc - last_rise);
                    end
                end
                last_rise = cyc;
                n_rise++;
            end
            if (dn_b) begin
                n_cmp++;
                if (!stb_b || fv_b || (last_done >= 0 && cyc - last_done != 150)) begin
                    n_bad++;
                    $display("FAIL div_done cyc=%0d got stb=%b fv=%b gap=%0d want stb=1 fv=0 gap=150",
                             cyc, stb_b, fv_b, cyc - last_done);
                end
                last_done = cyc;
                n_done++;
            end
            prev_bus = {fv_b, lv_b, px_b};
            prev_fv  = fv_b;
        end
        n_cmp++;
        if (n_rise != 4 || n_done != 3) begin
            n_bad++;
            $display("FAIL div_frames got rises=%0d dones=%0d want rises=4 dones=3", n_rise, n_done);
        end
        en_b = 1'b0;
    endtask

    task automatic test_bars();
        int tr[5], tc[5], tv[5];
        int row, col, hits;
        logic prev_lv;
`ifdef D5M_PATTERN_BAYER_EN
        tr = '{0, 1, 0, 0, 1};
        tc = '{81, 160, 401, 161, 240};
        tv = '{4095, 4095, 4095, 0, 0};
`else
        tr = '{0, 0, 0, 0, 1};
        tc = '{0, 79, 80, 639, 160};
        tv = '{0, 0, 585, 4095, 1170};
`endif
        row = 0; col = 0; hits = 0; prev_lv = 1'b0;
        en_c  = 1'b1;
        pat_c = 2'd0;
        do_reset();
        for (int cyc = 0; cyc < 6000 && row < 2; cyc++) begin
            @(negedge clk);
            if (stb_c) begin
                if (lv_c) begin
                    for (int k = 0; k < 5; k++) begin
                        if (tr[k] == row && tc[k] == col) begin
                            hits++;
                            n_cmp++;
                            if (px_c !== 12'(tv[k])) begin
                                n_bad++;
                                $display("FAIL bars row=%0d col=%0d got %0d want %0d", row, col, px_c, tv[k]);
                            end
                        end
                    end
                    col++;
                end else begin
                    if (prev_lv) begin
                        row++;
                        col = 0;
                    end
                    n_cmp++;
                    if (px_c !== 12'd0) begin
                        n_bad++;
                        $display("FAIL bars_blank_data row=%0d got %0d want 0", row, px_c);
                    end
                end
                prev_lv = lv_c;
            end
        end
        n_cmp++;
        if (hits != 5 || row != 2) begin
            n_bad++;
            $display("FAIL bars_coverage got hits=%0d rows=%0d want hits=5 rows=2", hits, row);
        end
        en_c = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_enable_drop();
        test_reset_midframe();
        test_clkdiv();
        test_bars();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/d5m_pattern_source.md
Name: d5m_pattern_source

Overview:
- Synthetic image-sensor transmitter that drives the same pixel-bus signalling the camera driver receives from the TRDB-D5M: frame valid, line valid, 12-bit pixel data, and a pixel strobe.
- Replaces the physical sensor in simulation and board bring-up, so the camera-to-VGA path can be exercised with known, checkable frames.
- Generates a selectable test pattern with programmable active area and blanking.

Parameters:
- ACTIVE_COLS, 640, active pixels per line (>=8, multiple of 8).
- ACTIVE_ROWS, 480, active lines per frame (>=2).
- H_BLANK, 16, pixel ticks of LVAL-low between lines and before the first line (>=1).
- V_BLANK_LINES, 4, line periods of FVAL-low after each frame (>=1).
- DATA_WIDTH, 12, pixel data width.
- CLK_DIV, 2, clock cycles per pixel tick (>=1).

Ports:
- piul1Clock  in  1  system clock.
- piul1Reset_n  in  1  asynchronous active-low reset.
- piul1Enable  in  1  level; run frames while high.
- piulPattern  in  2  0=colour bars, 1=diagonal ramp, 2=checkerboard, 3=frame-count flat field.
- poul1PixelStrobe  out  1  one-cycle pulse per pixel tick; sink samples bus when high.
- poul1FrameValid  out  1  FVAL.
- poul1LineValid  out  1  LVAL.
- poulPixelData  out  DATA_WIDTH  pixel value; 0 whenever LVAL low.
- poul1FrameDone  out  1  one-cycle pulse on the tick FVAL falls.
- poulFrameCount  out  16  completed frames, wraps 0xFFFF->0.
- poul1Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, asserted): every output 0; state IDLE; divider, column, row and frame counters 0. Assertion mid-frame clears outputs immediately; no partial-frame completion.
- Tick generation: a divider counts 0..CLK_DIV-1; a tick occurs on the cycle it equals CLK_DIV-1. With CLK_DIV=1, every cycle is a tick.
- Registered outputs: all outputs update only on tick edges. poul1PixelStrobe is high for exactly the cycle following each tick edge.
- The divider runs continuously out of reset. In IDLE, strobe still pulses while FVAL, LVAL and data stay 0.
- FSM states: IDLE, FRAME_START, LINE_ACTIVE, LINE_BLANK, FRAME_BLANK. All transitions occur on ticks.
- IDLE -> FRAME_START: on a tick with piul1Enable=1. piulPattern is latched here and held for the whole frame.
- FRAME_START: FVAL=1, LVAL=0 for H_BLANK ticks, then LINE_ACTIVE with row=0.
- LINE_ACTIVE: FVAL=1, LVAL=1 for ACTIVE_COLS ticks; col runs 0..ACTIVE_COLS-1.
  - Row < ACTIVE_ROWS-1: go to LINE_BLANK.
  - Last row: go to FRAME_BLANK. FVAL and LVAL fall on the same tick, FrameDone pulses, and FrameCount increments on that tick.
- LINE_BLANK: FVAL=1, LVAL=0 for H_BLANK ticks; row++, then LINE_ACTIVE.
- FRAME_BLANK: FVAL=0 for V_BLANK_LINES*(ACTIVE_COLS+H_BLANK) ticks. Then FRAME_START if piul1Enable=1, else IDLE.
- Enable deassertion mid-frame: the current frame always completes, followed by its full FRAME_BLANK. Frames are never truncated.
- Ticks per frame: H_BLANK + ACTIVE_ROWS*ACTIVE_COLS + (ACTIVE_ROWS-1)*H_BLANK + V_BLANK_LINES*(ACTIVE_COLS+H_BLANK).
- Pattern values. MAXV = 2^DATA_WIDTH-1. All arithmetic is truncated to DATA_WIDTH.
  - Bars: bar index b = col/(ACTIVE_COLS/8), 0..7; value = (b*MAXV)/7, from a constant table.
  - Ramp: (col+row) mod 2^DATA_WIDTH.
  - Checker: MAXV if (col[3]^row[3]), else 0.
  - Flat: FrameCount[DATA_WIDTH-1:0], using the count value at frame start.

Optional Feature:
- Macro: D5M_PATTERN_BAYER_EN.
- Defined: pattern 0 emits 8 colour bars (white, yellow, cyan, green, magenta, red, blue, black) as a Bayer mosaic.
  - Mosaic layout: even row/even col=G, even row/odd col=R, odd row/even col=B, odd row/odd col=G.
  - Pixel value is MAXV if that channel is on in the bar colour, else 0.
- Undefined: pattern 0 emits the grey-level bars above. No mosaic logic is synthesised.

Test Plan:
- Small-config frame: ACTIVE_COLS=8, ACTIVE_ROWS=4, H_BLANK=2, V_BLANK_LINES=1, CLK_DIV=1, Enable held high -> frame repeats every 50 ticks.
  - FVAL high for 40 ticks; 4 LVAL bursts of 8 ticks separated by 2-tick gaps.
  - FrameDone pulses on ticks 40, 90, ...; FrameCount = 1, 2, ...
- Ramp, same config -> row 2 data = 2,3,...,9; data = 0 in every LVAL-low tick.
- CLK_DIV=3 -> strobe every 3rd cycle; FVAL, LVAL and data change only on strobe cycles; frame length 150 cycles.
- Enable dropped at row 1 col 3 -> frame finishes all 4 rows and the 10-tick FRAME_BLANK, then IDLE with Busy=0; no further FVAL.
- Reset asserted mid LINE_ACTIVE -> all outputs 0 within the same cycle. After release with Enable=1, a full frame starts with FrameCount=0.
- Bars, default config, with and without D5M_PATTERN_BAYER_EN:
  - Without: col 80 = 585, col 639 = 4095.
  - With: row 0 col 81 (yellow, R) = 4095; row 1 col 160 (cyan, B) = 4095; row 0 col 401 (red, R) = 4095.
